button_input_encoder: RTL
=========================

BUTTON_INPUT_ENCODER -- requirements
Module: button_input_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive stable synchronized cycles required to accept a button level change; legal range 1..65535.
REQ-002 Port clk, input, 1, is the single clock; every register samples on its rising edge.
REQ-003 Port rst, input, 1, is the reset: synchronous and active-high.
REQ-004 Port en, input, 1, enables acceptance of new presses and is driven by the mode FSM's input_handler_en.
REQ-005 Port btn, input, 8, carries raw asynchronous push-button levels; 1 means pressed, and bit i maps to code i.
REQ-006 Port key_valid, output, 1, is a one-cycle pulse marking an accepted single-button press.
REQ-007 Port key_code, output, 3, carries the encoded button index; it is valid with key_valid and holds until the next accepted press.
REQ-008 Port key_error, output, 1, is a one-cycle pulse marking a press event in which more than one button is stable-pressed.
REQ-009 Port busy, output, 1, is 1 while the FSM is in HELD.

Function
REQ-010 btn shall pass through a 2-flop synchronizer per bit; the synchronized value is sync.
REQ-011 Each bit shall have a debounce counter of width $clog2(DEBOUNCE_CYCLES+1) and a stable level.
- When sync differs from stable, the counter increments.
- When they are equal, the counter clears.
- When the counter reaches DEBOUNCE_CYCLES, stable toggles and the counter clears in the same cycle.
REQ-012 A counter shall never wrap; any reversion of sync before it reaches DEBOUNCE_CYCLES discards the partial count.
REQ-013 The FSM shall have two states, IDLE and HELD, with all outputs registered.
REQ-014 From IDLE, when stable != 0, the FSM shall go to HELD in the next cycle. In that cycle it pulses exactly one of the following:
- key_valid with key_code set to the index, if exactly one bit of stable is set and en=1;
- key_error, if two or more bits are set and en=1;
- nothing, if en=0.
REQ-015 In HELD, no pulse shall be emitted; extra buttons pressed or released while any bit of stable remains set are ignored.
REQ-016 From HELD, when stable == 0, the FSM shall return to IDLE in the next cycle.
REQ-017 A press shall never be emitted late: raising en while a button is already held produces no pulse.
REQ-018 key_valid and key_error shall never both be 1 in the same cycle, and each pulse shall last exactly one cycle.
REQ-019 For a clean press the latency shall be DEBOUNCE_CYCLES+3 cycles from the first clk edge that samples btn high to key_valid high: 2 synchronizer cycles, then DEBOUNCE_CYCLES counting cycles including the stable toggle, then 1 FSM cycle.
REQ-020 When multiple bits reach stable in the same cycle, that event shall be classified as multi-press (REQ-014).

Reset
REQ-021 While rst=1 at a clk edge, the following shall be cleared:
- synchronizers, counters and stable cleared to 0;
- state set to IDLE;
- key_valid, key_error, busy and key_code set to 0.
REQ-022 Reset asserted mid-operation shall abort any debounce or HELD state. A button still held after rst deasserts shall be treated as a fresh press, emitted after the full REQ-019 latency if en=1.

Configuration
REQ-023 Macro BUTTON_DEBOUNCE_EN controls the debounce stage.
- Defined: the debounce counters of REQ-011/012 are compiled in.
- Undefined: counters are omitted, stable = sync registered once, latency becomes 3 cycles, and DEBOUNCE_CYCLES is ignored.
REQ-024 All other behaviour shall be identical with and without BUTTON_DEBOUNCE_EN.

Verification (BUTTON_DEBOUNCE_EN defined, DEBOUNCE_CYCLES=4)
REQ-025 Clean press: en=1, btn=8'h20 held for 20 cycles, then 0 -> a single key_valid pulse 7 cycles after the first sample with key_code=3'd5; busy=1 from that cycle until 7 cycles after release.
REQ-026 Bounce: en=1, btn bit 2 toggles every 2 cycles for 12 cycles, then holds 1 -> exactly one key_valid with key_code=3'd2, 7 cycles after the hold begins.
REQ-027 Multi-press: en=1, btn=8'h05 applied in one cycle -> one key_error pulse, no key_valid, key_code unchanged.
REQ-028 Gating: en=0, btn=8'h01 held; en rises after 10 cycles -> no pulse; then release, re-press -> key_valid with key_code=3'd0.
REQ-029 Overlap: btn=8'h10 held, then 8'h18 -> one key_valid with key_code=3'd4 only; pulses stay 0 until all buttons are released and the FSM returns to IDLE.
REQ-030 Reset: rst=1 for 1 cycle mid-hold of 8'h80 with en=1 -> outputs 0 during reset, then key_valid with key_code=3'd7 exactly 7 cycles after rst deasserts.

Source files
------------

// File: rtl/button_input_encoder.sv
// -----------------------------------------------------------------------------
// button_input_encoder
//
// Turns eight raw push-button levels into single-key events. Each button is
// synchronised, optionally debounced, and a two-state FSM (IDLE/HELD) reports
// the first press it sees. A lone button gives a key_valid pulse with its
// index on key_code. Several buttons together give a key_error pulse. The FSM
// then waits in HELD until every button is released, so nothing else is
// reported while any button stays down.
//
// Configuration:
//   BUTTON_DEBOUNCE_EN (macro)
//     Defined:   each bit has a counter that needs DEBOUNCE_CYCLES consecutive
//                cycles of a changed level before that level is accepted.
//                Press-to-pulse latency is DEBOUNCE_CYCLES+3 clocks.
//     Undefined: no counters. The synchronised level is used directly,
//                latency is 3 clocks and DEBOUNCE_CYCLES has no effect.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   en         in   allows new presses to be reported (input_handler_en)
//   btn[7:0]   in   raw asynchronous button levels, 1 = pressed, bit i = code i
//   key_valid  out  one-cycle pulse: an accepted single-button press
//   key_code   out  index of the accepted button; holds until the next press
//   key_error  out  one-cycle pulse: a press event with 2+ buttons down
//   busy       out  1 while the FSM is in HELD
//
// Handshake: key_valid and key_error are fire-and-forget strobes with no
// ready. A consumer samples key_code in the cycle key_valid is 1. The two
// strobes are never high together and each lasts exactly one cycle.
// -----------------------------------------------------------------------------
module button_input_encoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] btn,
   output logic       key_valid,
   output logic [2:0] key_code,
   output logic       key_error,
   output logic       busy
);

   // Legal range is 1..65535. Zero would leave a counter with nothing to
   // count, so reject it when the design is elaborated.
   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_param
      $error("button_input_encoder: DEBOUNCE_CYCLES out of range 1..65535");
   end

   // --------------------------------------------------------------------------
   // Two-flop synchroniser per bit
   // --------------------------------------------------------------------------
   logic [7:0] sync1_q;
   logic [7:0] sync2_q;
   logic [7:0] sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
      end
   end

   assign sync = sync2_q;

   // --------------------------------------------------------------------------
   // Stable level per button
   // --------------------------------------------------------------------------
   logic [7:0] stable;

`ifdef BUTTON_DEBOUNCE_EN
   localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   // The count that would reach DEBOUNCE_CYCLES on this edge. Toggling at
   // that point means a counter never holds DEBOUNCE_CYCLES itself, so it
   // cannot wrap.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [7:0][CNT_W-1:0] cnt_q;
   logic [7:0][CNT_W-1:0] cnt_d;
   logic [7:0]            stable_q;
   logic [7:0]            stable_d;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      for (int i = 0; i < 8; i++) begin
         // A level that matches stable, even briefly, drops any partial count.
         if (sync[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = sync[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         stable_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable = stable_q;
`else
   // Without debounce the synchroniser output is the stable level. The FSM
   // registers it once more, which gives the 3-cycle latency.
   assign stable = sync;
`endif

   // --------------------------------------------------------------------------
   // Press classification helpers
   // --------------------------------------------------------------------------
   logic       any_down;
   logic       single_down;
   logic [2:0] down_idx;

   assign any_down    = (stable != 8'h00);
   // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
   assign single_down = any_down && ((stable & (stable - 8'h01)) == 8'h00);

   always_comb begin
      down_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (stable[i]) begin
            down_idx = 3'(i);
         end
      end
   end

   // --------------------------------------------------------------------------
   // IDLE / HELD FSM, all outputs registered
   // --------------------------------------------------------------------------
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } state_e;

   state_e     state_q;
   state_e     state_d;
   logic       key_valid_q;
   logic       key_valid_d;
   logic       key_error_q;
   logic       key_error_d;
   logic [2:0] key_code_q;
   logic [2:0] key_code_d;
   logic       busy_q;
   logic       busy_d;

   always_comb begin
      state_d     = state_q;
      key_valid_d = 1'b0;
      key_error_d = 1'b0;
      key_code_d  = key_code_q;

      case (state_q)
         ST_IDLE: begin
            // HELD is entered even when en is low. A press that arrived while
            // disabled is used up here and is never reported later.
            if (any_down) begin
               state_d = ST_HELD;
               if (en) begin
                  if (single_down) begin
                     key_valid_d = 1'b1;
                     key_code_d  = down_idx;
                  end else begin
                     key_error_d = 1'b1;
                  end
               end
            end
         end
         ST_HELD: begin
            // Extra presses and partial releases are ignored until every
            // button is up.
            if (!any_down) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_HELD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         key_valid_q <= 1'b0;
         key_error_q <= 1'b0;
         key_code_q  <= 3'd0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_valid_q <= key_valid_d;
         key_error_q <= key_error_d;
         key_code_q  <= key_code_d;
         busy_q      <= busy_d;
      end
   end

   assign key_valid = key_valid_q;
   assign key_error = key_error_q;
   assign key_code  = key_code_q;
   assign busy      = busy_q;

endmodule
